// File: rtl/register_file_pkg.sv
// Shared types and default parameters for the 2-read/1-write register file.
package register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;
    localparam int unsigned DEFAULT_BYPASS     = 1;

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: range check, write-forwarding mux, data/valid registers.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BYPASS     = DEFAULT_BYPASS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  accept,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] entry_data,
    input  logic                  wr_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic                  in_range;
    logic                  forward;
    logic                  fire;
    logic [DATA_WIDTH-1:0] next_data;

    assign in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign fire     = accept && rd_en;
    assign rd_err   = fire && !in_range;
    // wr_fire is already qualified by range and FSM state in the top level
    assign forward  = (BYPASS != 0) && wr_fire && (wr_addr == rd_addr);

    always_comb begin
        next_data = entry_data;
        if (!in_range) begin
            next_data = '0;
        end else if (forward) begin
            next_data = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= fire;
            if (fire) begin
                rd_data <= next_data;
            end
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x DATA_WIDTH register file: two registered read ports, one write port,
// and a one-entry-per-cycle sweep clear engine.
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BYPASS     = DEFAULT_BYPASS
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd0_en,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd0_valid,
    input  logic                  rd1_en,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data,
    output logic                  rd1_valid,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    rf_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0] ptr, ptr_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  idle;
    logic                  clearing;
    logic                  wr_in_range;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] rd0_word, rd1_word;
    logic                  rd0_err, rd1_err;

    assign idle        = (state == IDLE);
    assign clearing    = (state == CLEAR);
    assign busy        = clearing;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign wr_fire     = idle && wr_en && wr_in_range;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                ptr_next = ptr + ADDR_WIDTH'(1);
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clearing && (ptr == ADDR_WIDTH'(i))) begin
                    mem[i] <= '0;
                end else if (wr_fire && (wr_addr == ADDR_WIDTH'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Decoded select so an out-of-range address never indexes the array
    always_comb begin
        rd0_word = '0;
        rd1_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd0_addr == ADDR_WIDTH'(i)) rd0_word = mem[i];
            if (rd1_addr == ADDR_WIDTH'(i)) rd1_word = mem[i];
        end
    end

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_rd0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .accept    (idle),
        .rd_en     (rd0_en),
        .rd_addr   (rd0_addr),
        .entry_data(rd0_word),
        .wr_fire   (wr_fire),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (rd0_data),
        .rd_valid  (rd0_valid),
        .rd_err    (rd0_err)
    );

    register_file_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .BYPASS    (BYPASS)
    ) u_rd1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .accept    (idle),
        .rd_en     (rd1_en),
        .rd_addr   (rd1_addr),
        .entry_data(rd1_word),
        .wr_fire   (wr_fire),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (rd1_data),
        .rd_valid  (rd1_valid),
        .rd_err    (rd1_err)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= idle && ((wr_en && !wr_in_range) || rd0_err || rd1_err);
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench: three configurations (default, BYPASS=0, DEPTH=12) share one stimulus stream.
module tb_register_file_2r1w;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear_req;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd0_en, rd1_en;
    logic [3:0] rd0_addr, rd1_addr;

    logic       a_busy, a_rd0_valid, a_rd1_valid, a_addr_err;
    logic [7:0] a_rd0_data, a_rd1_data;
    logic       b_busy, b_rd0_valid, b_rd1_valid, b_addr_err;
    logic [7:0] b_rd0_data, b_rd1_data;
    logic       c_busy, c_rd0_valid, c_rd1_valid, c_addr_err;
    logic [7:0] c_rd0_data, c_rd1_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    register_file_2r1w dut (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(a_rd0_data), .rd0_valid(a_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(a_rd1_data), .rd1_valid(a_rd1_valid),
        .addr_err(a_addr_err)
    );

    register_file_2r1w #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(b_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(b_rd0_data), .rd0_valid(b_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(b_rd1_data), .rd1_valid(b_rd1_valid),
        .addr_err(b_addr_err)
    );

    register_file_2r1w #(.DEPTH(12)) dut12 (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .busy(c_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(c_rd0_data), .rd0_valid(c_rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(c_rd1_data), .rd1_valid(c_rd1_valid),
        .addr_err(c_addr_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        wr_en     = 1'b0;
        rd0_en    = 1'b0;
        rd1_en    = 1'b0;
        clear_req = 1'b0;
    endtask

    initial begin
        int cnt16;
        int cnt12;
        int busy_bad;
        int guard;

        reset_n  = 1'b0;
        quiet();
        wr_addr  = '0; wr_data  = '0;
        rd0_addr = '0; rd1_addr = '0;
        #3;
        check("reset_rd0_data",  a_rd0_data,  8'h00);
        check("reset_rd1_data",  a_rd1_data,  8'h00);
        check("reset_rd0_valid", {7'd0, a_rd0_valid}, 8'h00);
        check("reset_busy",      {7'd0, a_busy},      8'h00);
        check("reset_addr_err",  {7'd0, a_addr_err},  8'h00);
        step();
        reset_n = 1'b1;

        // Read of a reset entry on both ports
        rd0_en = 1'b1; rd0_addr = 4'd3; rd1_en = 1'b1; rd1_addr = 4'd3;
        step();
        check("rd3_p0_data",  a_rd0_data, 8'h00);
        check("rd3_p1_data",  a_rd1_data, 8'h00);
        check("rd3_p0_valid", {7'd0, a_rd0_valid}, 8'h01);
        check("rd3_p1_valid", {7'd0, a_rd1_valid}, 8'h01);
        quiet();
        step();
        check("rd3_p0_valid_drop", {7'd0, a_rd0_valid}, 8'h00);
        check("rd3_p1_valid_drop", {7'd0, a_rd1_valid}, 8'h00);

        // Write then read next cycle
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hA5;
        step();
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd7; rd1_en = 1'b1; rd1_addr = 4'd6;
        step();
        check("wr7_rd7", a_rd0_data, 8'hA5);
        check("wr7_rd6", a_rd1_data, 8'h00);

        // Forwarding: preload 0xA5 at addr 2, then write 0x3C while reading it
        quiet();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hA5;
        step();
        wr_data = 8'h3C;
        rd0_en = 1'b1; rd0_addr = 4'd2; rd1_en = 1'b1; rd1_addr = 4'd2;
        step();
        check("bypass1_p0",  a_rd0_data, 8'h3C);
        check("bypass1_p1",  a_rd1_data, 8'h3C);
        check("bypass0_p0",  b_rd0_data, 8'hA5);
        check("bypass0_p1",  b_rd1_data, 8'hA5);
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd2;
        step();
        check("bypass0_after", b_rd0_data, 8'h3C);

        // Out of range on the 12-deep instance
        quiet();
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h11;
        rd0_en = 1'b1; rd0_addr = 4'd13;
        step();
        check("oor_err",       {7'd0, c_addr_err},  8'h01);
        check("oor_rd0_data",  c_rd0_data,          8'h00);
        check("oor_rd0_valid", {7'd0, c_rd0_valid}, 8'h01);
        check("inrange16_err", {7'd0, a_addr_err},  8'h00);
        check("inrange16_fwd", a_rd0_data,          8'h11);
        quiet();
        step();
        check("oor_err_drop", {7'd0, c_addr_err}, 8'h00);
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'h22;
        rd0_en = 1'b1; rd0_addr = 4'd12; rd1_en = 1'b1; rd1_addr = 4'd14;
        step();
        check("oor_multi_err", {7'd0, c_addr_err}, 8'h01);
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd7;
        step();
        check("oor_entries_kept", c_rd0_data, 8'hA5);

        // Fill with 0xFF, then sweep-clear with ignored accesses presented throughout
        quiet();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'hFF;
            step();
        end
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd4;
        step();
        check("fill_rd4", a_rd0_data, 8'hFF);
        quiet();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
        rd0_en = 1'b1; rd0_addr = 4'd4; rd1_en = 1'b1; rd1_addr = 4'd4;
        cnt16 = 0; cnt12 = 0; busy_bad = 0; guard = 0;
        while ((a_busy || c_busy) && guard < 100) begin
            if (a_busy) begin
                cnt16++;
                if (a_rd0_valid || a_rd1_valid || a_addr_err) busy_bad++;
            end
            if (c_busy) cnt12++;
            step();
            guard++;
        end
        quiet();
        checks++;
        assert (guard < 100) else begin
            failures++;
            $error("FAIL clear_timeout observed=%0d expected=<100", guard);
        end
        check("busy_cycles_16",   8'(cnt16),    8'd16);
        check("busy_cycles_12",   8'(cnt12),    8'd12);
        check("busy_no_activity", 8'(busy_bad), 8'd0);
        check("busy_rd0_hold",    a_rd0_data,   8'hFF);
        for (int i = 0; i < 16; i++) begin
            rd0_en = 1'b1; rd0_addr = 4'(i); rd1_en = 1'b1; rd1_addr = 4'(15 - i);
            step();
            check($sformatf("cleared_p0_%0d", i), a_rd0_data, 8'h00);
            check($sformatf("cleared_p1_%0d", 15 - i), a_rd1_data, 8'h00);
        end

        // Reset in the middle of a sweep
        quiet();
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h77;
        step();
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd9;
        step();
        check("pre_abort_rd9", a_rd0_data, 8'h77);
        quiet();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (5) step();
        check("abort_busy_before", {7'd0, a_busy}, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy",     {7'd0, a_busy},      8'h00);
        check("abort_rd0_data", a_rd0_data,          8'h00);
        check("abort_rd0_vld",  {7'd0, a_rd0_valid}, 8'h00);
        check("abort_addr_err", {7'd0, a_addr_err},  8'h00);
        #2 reset_n = 1'b1;
        step();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h42;
        step();
        quiet();
        rd0_en = 1'b1; rd0_addr = 4'd0; rd1_en = 1'b1; rd1_addr = 4'd9;
        step();
        check("post_abort_rd0", a_rd0_data, 8'h42);
        check("post_abort_rd9", a_rd1_data, 8'h00);
        check("post_abort_busy", {7'd0, a_busy}, 8'h00);
        quiet();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Parametrised successor to the 16×8 single-read register unit: DEPTH entries of DATA_WIDTH bits with two independent registered read ports and one write port. Same-cycle write-to-read forwarding is selectable, and a sequenced clear engine zeroes the array one entry per cycle. It sits between the datapath control FSM and the ALU operand buses, supplying two operands per cycle.

## Interface
- DATA_WIDTH, 8, bits per entry
- DEPTH, 16, number of entries (≥2, need not be a power of two)
- ADDR_WIDTH, $clog2(DEPTH), address width
- BYPASS, 1, 1 = read of the address being written in the same cycle returns new data; 0 = returns old data
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  request array sweep-clear (sampled in IDLE only)
- busy  out  1  high while clear sweep is in progress
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd0_en / rd1_en  in  1  read strobe, port 0 / 1
- rd0_addr / rd1_addr  in  ADDR_WIDTH  read address
- rd0_data / rd1_data  out  DATA_WIDTH  registered read data
- rd0_valid / rd1_valid  out  1  one-cycle pulse: rdN_data updated this cycle
- addr_err  out  1  one-cycle pulse: an enabled access used address ≥ DEPTH

## Operation
- Reset (reset_n low): all entries, rd0_data, rd1_data = 0; rd*_valid, busy, addr_err = 0; FSM = IDLE. Takes effect immediately, independent of clock.
- FSM states: IDLE, CLEAR.
  - IDLE: reads/writes serviced. clear_req=1 → CLEAR, sweep pointer = 0. Accesses presented in the same cycle as clear_req still complete normally.
  - CLEAR: entry[ptr] ← 0, ptr+1 each cycle. After the write to entry DEPTH-1 → IDLE. clear_req ignored.
- During CLEAR: wr_en and rdN_en are ignored; rd*_valid stays 0; rd*_data hold their value; addr_err stays 0.
- Write: wr_en=1 and wr_addr < DEPTH → entry[wr_addr] ← wr_data at the edge.
- Read: rdN_en=1 and rdN_addr < DEPTH → rdN_data ← entry[rdN_addr] at the edge, rdN_valid=1 for the following cycle.
- Forwarding: rdN_en, wr_en, rdN_addr==wr_addr in the same cycle → rdN_data = wr_data if BYPASS=1, else the prior contents. Both ports may read the same address simultaneously.
- Not enabled: rdN_data holds its last value; rdN_valid=0.
- Out of range (addr ≥ DEPTH):
  - Write is dropped.
  - Read loads 0 with rdN_valid=1.
  - addr_err pulses once per cycle regardless of how many ports erred.

## Timing
- Read latency 1 cycle (address at edge T → data/valid visible after edge T, sampled at edge T+1).
- Write visible to a non-forwarded read issued at the next edge.
- Clear: clear_req sampled at edge T; busy=1 after T through after edge T+DEPTH; entry k zeroed at edge T+1+k; back to IDLE after edge T+DEPTH, accepting accesses at edge T+DEPTH+1.
- reset_n low mid-sweep aborts it; all entries zero, FSM IDLE.
- No back-pressure; every enabled access in IDLE completes in one cycle.

## Structure
- Package register_file_pkg: FSM state enum (IDLE, CLEAR), default-parameter constants.
- Sub-module register_file_read_port: address-range check, bypass mux, output/valid registers. Instantiated twice.
- Top-level holds the storage array, write logic, and clear FSM/pointer.

## Test plan
- Reset then read addr 3 on both ports → rd0_data=rd1_data=0x00, both valid pulse once.
- Write 0xA5 to addr 7; next cycle read 7 on port 0, addr 6 on port 1 → 0xA5 and 0x00 after 1 cycle.
- BYPASS=1: write 0x3C to addr 2 and read addr 2 in the same cycle → rd0_data=0x3C; BYPASS=0 → prior value 0xA5 (preloaded).
- DEPTH=12: write 0x11 to addr 13, read addr 13 → addr_err pulse, rd0_data=0x00, entries unchanged.
- Fill all entries with 0xFF, pulse clear_req → busy high exactly DEPTH cycles, reads/writes ignored meanwhile; afterwards every entry reads 0x00.
- Drop reset_n during CLEAR at ptr=5 → busy=0 immediately, all outputs 0; after release, a write to addr 0 with value 0x42 followed by a read returns 0x42.
